// File: rtl/pixel_uart_tx_if.sv
// Frame-buffer read port plus frame control handshake between the pixel
// sender (master) and the frame source / host logic (slave).
interface pixel_uart_tx_if #(
   parameter int ADDR_W = 16
);
   logic              start;
   logic              busy;
   logic              frame_done;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [23:0]       rd_data;

   modport master (
      input  start,
      input  rd_data,
      output busy,
      output frame_done,
      output rd_en,
      output rd_addr
   );

   modport slave (
      output start,
      output rd_data,
      input  busy,
      input  frame_done,
      input  rd_en,
      input  rd_addr
   );
endinterface

// File: rtl/pixel_uart_tx.sv
// Streams one frame (header byte, then R,G,B per pixel) from the frame buffer
// over UART 8N1, with its own baud timing, serializer and sequencing FSM.
module pixel_uart_tx #(
   parameter int          CLK_HZ     = 100_000_000,
   parameter int          BAUD       = 9600,
   parameter int          NUM_PIXELS = 40800,
   parameter logic [7:0]  HEADER     = 8'hAA,
   parameter int          ADDR_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   pixel_uart_tx_if.master  fb,
   output logic             tx_o
);

   localparam int                BIT_CYCLES = CLK_HZ / BAUD;
   localparam int                BAUD_W     = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(BIT_CYCLES - 1);
   localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_PIXELS - 1);
   localparam logic [3:0]        STOP_BIT   = 4'd9;

   typedef enum logic [2:0] {
      IDLE, HDR, FETCH, LATCH, SEND_R, SEND_G, SEND_B, DONE
   } state_e;

   state_e              state_q;
   logic [BAUD_W-1:0]   baud_cnt_q;
   logic [3:0]          bit_cnt_q;
   logic [ADDR_W-1:0]   idx_q;
   logic [ADDR_W-1:0]   rd_addr_q;
   logic [23:0]         pixel_q;
   logic                tx_q;
   logic                busy_q;
   logic                rd_en_q;
   logic                frame_done_q;

   logic                sending;
   logic                byte_done;
   logic [7:0]          cur_byte;

   // Byte currently on the line is selected by state, so the serializer
   // reads straight from the header constant or the latched pixel.
   always_comb begin
      cur_byte = HEADER;
      sending  = 1'b1;
      case (state_q)
         HDR:     cur_byte = HEADER;
         SEND_R:  cur_byte = pixel_q[23:16];
         SEND_G:  cur_byte = pixel_q[15:8];
         SEND_B:  cur_byte = pixel_q[7:0];
         default: sending  = 1'b0;
      endcase
   end

   assign byte_done = sending && (bit_cnt_q == STOP_BIT) && (baud_cnt_q == BAUD_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         baud_cnt_q   <= '0;
         bit_cnt_q    <= '0;
         idx_q        <= '0;
         rd_addr_q    <= '0;
         pixel_q      <= '0;
         tx_q         <= 1'b1;
         busy_q       <= 1'b0;
         rd_en_q      <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         rd_en_q      <= 1'b0;
         frame_done_q <= 1'b0;

         // NOTE: the state case below assigns tx_q again when a new byte starts;
         // with non-blocking assignments the last one in the block wins.
         if (sending) begin
            if (baud_cnt_q == BAUD_LAST) begin
               baud_cnt_q <= '0;
               bit_cnt_q  <= byte_done ? 4'd0 : bit_cnt_q + 4'd1;
               tx_q       <= (bit_cnt_q < 4'd8) ? cur_byte[bit_cnt_q[2:0]] : 1'b1;
            end else begin
               baud_cnt_q <= baud_cnt_q + BAUD_W'(1);
            end
         end

         case (state_q)
            IDLE: begin
               if (fb.start) begin
                  state_q    <= HDR;
                  busy_q     <= 1'b1;
                  idx_q      <= '0;
                  tx_q       <= 1'b0;
                  baud_cnt_q <= '0;
                  bit_cnt_q  <= '0;
               end
            end
            HDR: begin
               if (byte_done) begin
                  state_q   <= FETCH;
                  rd_en_q   <= 1'b1;
                  rd_addr_q <= idx_q;
               end
            end
            FETCH: state_q <= LATCH;
            LATCH: begin
               // Read data arrives one cycle after the strobe, i.e. now.
               pixel_q <= fb.rd_data;
               tx_q    <= 1'b0;
               state_q <= SEND_R;
            end
            SEND_R: begin
               if (byte_done) begin
                  tx_q    <= 1'b0;
                  state_q <= SEND_G;
               end
            end
            SEND_G: begin
               if (byte_done) begin
                  tx_q    <= 1'b0;
                  state_q <= SEND_B;
               end
            end
            SEND_B: begin
               if (byte_done) begin
                  if (idx_q == LAST_IDX) begin
                     state_q      <= DONE;
                     busy_q       <= 1'b0;
                     frame_done_q <= 1'b1;
                  end else begin
                     idx_q     <= idx_q + ADDR_W'(1);
                     rd_addr_q <= idx_q + ADDR_W'(1);
                     rd_en_q   <= 1'b1;
                     state_q   <= FETCH;
                  end
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign tx_o          = tx_q;
   assign fb.busy       = busy_q;
   assign fb.rd_en      = rd_en_q;
   assign fb.rd_addr    = rd_addr_q;
   assign fb.frame_done = frame_done_q;

endmodule

// File: doc/pixel_uart_tx.md
Name: pixel_uart_tx

Overview:
- Transmit side of the PC↔FPGA pixel link: streams one frame from the frame buffer over UART 8N1.
- Wire format is identical to what uart_rx_fifo + data_assembly_fsm consume: header byte 0xAA, then per pixel R, G, B bytes.
- Sits between the frame-buffer read port and the board TX pin.
- Contains its own baud-tick generator, byte serializer and frame-sequencing FSM.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency in Hz.
- BAUD, 9600, line rate; BIT_CYCLES = CLK_HZ/BAUD (integer division; 10416 at defaults).
- NUM_PIXELS, 40800, pixels per frame (addresses 0..NUM_PIXELS-1).
- HEADER, 8'hAA, frame header byte.
- ADDR_W, 16, frame-buffer address width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to send one frame; ignored while busy=1.
- rd_en  out  1  frame-buffer read strobe, one cycle per pixel.
- rd_addr  out  ADDR_W  pixel address, valid when rd_en=1.
- rd_data  in  24  {R[23:16],G[15:8],B[7:0]}; valid exactly 1 cycle after rd_en.
- tx  out  1  UART serial line, idle high.
- busy  out  1  high from the cycle after start is accepted until frame_done.
- frame_done  out  1  one-cycle pulse after the last stop bit of the frame.

Behaviour:
- Reset (async) values: tx=1, busy=0, rd_en=0, rd_addr=0, frame_done=0.
  - FSM returns to IDLE; bit counter, baud counter, pixel index and pixel latch all clear to 0.
  - Reset mid-byte drives tx high immediately; no partial byte is completed after reset release.
- Byte serializer:
  - 10 bit periods per byte: start bit (0), data[0]..data[7] LSB first, stop bit (1).
  - Each bit period is held exactly BIT_CYCLES clocks, using a baud counter that restarts at 0 at every byte start.
  - Asserts an internal byte_done in the final cycle of the stop bit.
- FSM states: IDLE, HDR, FETCH, LATCH, SEND_R, SEND_G, SEND_B, DONE.
  - IDLE: tx=1. When start=1 is sampled at cycle N, go to HDR; busy=1 and tx=0 (start bit) from cycle N+1.
  - HDR: send HEADER; on byte_done go to FETCH.
  - FETCH: one cycle, rd_en=1, rd_addr=pixel index; go to LATCH.
  - LATCH: one cycle, capture rd_data into a 24-bit register; go to SEND_R.
  - Line gap: tx stays high (stop level) for the 2 cycles of FETCH+LATCH, so the stop bit before each R byte is BIT_CYCLES+2 clocks. This is legal for the receiver.
  - SEND_R → SEND_G → SEND_B: each advances on byte_done. The next start bit begins the cycle after the previous byte_done (no inter-byte gap within a pixel).
  - After SEND_B byte_done:
    - if index == NUM_PIXELS-1, go to DONE;
    - else index+1 and go to FETCH.
  - DONE: one cycle, frame_done=1, busy=0 in the same cycle, then IDLE. A new start is accepted from the next cycle.
- Frame timing: one frame = (1 + 3·NUM_PIXELS) bytes. Total cycles from start to frame_done = (1+3·NUM_PIXELS)·10·BIT_CYCLES + 2·NUM_PIXELS + 1.
- rd_addr holds its last value outside FETCH and wraps to 0 at the next frame.
- No back-pressure: the sender owns frame-buffer read timing. rd_data is sampled only in LATCH.
- start asserted in the same cycle as frame_done is ignored (busy is still being cleared).

Test Plan:
- Basic frame: CLK_HZ=1000, BAUD=100 (BIT_CYCLES=10), NUM_PIXELS=3; memory model {0x112233, 0x445566, 0x778899}; pulse start → bench UART decoder reads AA 11 22 33 44 55 66 77 88 99; exactly one frame_done pulse; rd_addr sequence 0,1,2.
- Bit timing: same setup; measure every tx edge → each bit lasts 10 cycles; stop before each R byte lasts 12 cycles; tx falls 1 cycle after start is sampled; start→frame_done = 10·10·10 + 2·3 + 1 = 1007 cycles.
- Start while busy: pulse start again mid-frame and in the frame_done cycle → no extra header, byte stream unchanged, single frame_done.
- Reset mid-byte: assert reset during the G byte of pixel 1 → tx=1 and busy=0 immediately; after release, a new start sends AA 11 22 … from address 0.
- Loopback: defaults (9600 bps), NUM_PIXELS=2, pixels {0xFF0000, 0x00FF00}, tx wired to uart_rx_fifo.rx feeding data_assembly_fsm → pixel_done pulses twice with rgb_data 0xFF0000 then 0x00FF00, pixel_cnt 0 then 1.
- Back-to-back frames: start again the cycle after frame_done → second frame identical, begins with AA, no leftover latch data.
